// File: rtl/ibus_arbiter.sv
// ibus_arbiter: owns the single-port instruction ROM and lends it to the EX
// stage and the program loader. While the port is lent out, it asks the
// pipeline hold controller to freeze fetch. After a loader session ends, it
// asks for a restart at RESET_PC.
//
// Handshakes:
//   EX     - ex_ack_o and ex_data_o are registered and rise together in the
//            cycle after the data phase. A request that is still high when
//            the data phase ends is taken as a new back-to-back request.
//            After STARVE_LIM such reads, one fetch cycle is forced.
//   Loader - ld_ack_o marks the cycle in which a beat is accepted. A write
//            is acknowledged while it is presented in LOAD. A read is
//            acknowledged in its data cycle (LD_RD); ld_rdata_o holds the
//            word from the following cycle on.
module ibus_arbiter #(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int                 STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    // EX-stage ROM data reads
    input  logic              ex_req_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    output logic [DATA_W-1:0] ex_data_o,
    output logic              ex_ack_o,
    // UART/debug program loader
    input  logic              ld_req_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic [DATA_W-1:0] ld_rdata_o,
    output logic              ld_ack_o,
    // ROM port
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    // pipeline control
    output logic [2:0]        hold_req_o,
    output logic              jump_req_o,
    output logic [ADDR_W-1:0] jump_addr_o
);

    localparam int                CNT_W      = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIM);

    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_IF   = 3'b010;
    localparam logic [2:0] HOLD_ALL  = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EX_A,
        S_EX_D,
        S_LOAD,
        S_LD_RD,
        S_DRAIN
    } state_e;

    state_e            state_q,      state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] ex_data_q,    ex_data_d;
    logic              ex_ack_q,     ex_ack_d;
    logic [DATA_W-1:0] ld_rdata_q,   ld_rdata_d;

    logic [CNT_W-1:0]  starve_cnt_inc;

    assign starve_cnt_inc = starve_cnt_q + CNT_W'(1);

    // State register and the registered EX/loader read results.
    // NOTE: state uses non-blocking assignments so all flops update from
    // pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            starve_cnt_q <= '0;
            ex_data_q    <= '0;
            ex_ack_q     <= 1'b0;
            ld_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            ex_data_q    <= ex_data_d;
            ex_ack_q     <= ex_ack_d;
            ld_rdata_q   <= ld_rdata_d;
        end
    end

    // Next state, ROM port steering, and hold/ack/jump outputs.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        ex_data_d    = ex_data_q;
        ex_ack_d     = 1'b0;
        ld_rdata_d   = ld_rdata_q;
        mem_we_o     = 1'b0;
        mem_addr_o   = if_addr_i;
        hold_req_o   = HOLD_NONE;
        ld_ack_o     = 1'b0;
        jump_req_o   = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                starve_cnt_d = '0;
                if (ld_req_i) begin
                    state_d = S_LOAD;
                end else if (ex_req_i) begin
                    state_d = S_EX_A;
                end
            end

            S_EX_A: begin
                mem_addr_o = ex_addr_i;
                hold_req_o = HOLD_IF;
                state_d    = S_EX_D;
            end

            S_EX_D: begin
                // The ROM returns the EX word now; the port already points
                // back at the PC, so fetch resumes without a bubble.
                ex_data_d    = mem_rdata_i;
                ex_ack_d     = 1'b1;
                hold_req_o   = HOLD_IF;
                starve_cnt_d = starve_cnt_inc;
                if (ld_req_i) begin
                    state_d = S_LOAD;
                end else if (ex_req_i && (starve_cnt_inc < STARVE_MAX)) begin
                    state_d = S_EX_A;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_LOAD: begin
                hold_req_o = HOLD_ALL;
                mem_addr_o = ld_addr_i;
                if (!ld_req_i) begin
                    state_d = S_DRAIN;
                end else if (ld_we_i) begin
                    mem_we_o = 1'b1;
                    ld_ack_o = 1'b1;
                end else begin
                    state_d = S_LD_RD;
                end
            end

            S_LD_RD: begin
                // A session that ends here still completes this read.
                hold_req_o = HOLD_ALL;
                ld_rdata_d = mem_rdata_i;
                ld_ack_o   = 1'b1;
                state_d    = ld_req_i ? S_LOAD : S_DRAIN;
            end

            S_DRAIN: begin
                hold_req_o = HOLD_ALL;
                mem_addr_o = RESET_PC;
                jump_req_o = 1'b1;
                state_d    = S_FETCH;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign if_data_o   = mem_rdata_i;
    assign ex_data_o   = ex_data_q;
    assign ex_ack_o    = ex_ack_q;
    assign ld_rdata_o  = ld_rdata_q;
    assign mem_ce_o    = 1'b1;
    assign mem_wdata_o = ld_wdata_i;
    assign jump_addr_o = RESET_PC;

endmodule
